// File: rtl/mp_csa_accum.sv
// Carry-save multi-precision accumulator: single-cycle ACC/ACC_SHR into an (S,C) pair,
// chunk-serial RESOLVE (S <= S + C) and conditional subtract CSUB (S <= S - A if no borrow).
module mp_csa_accum #(
  parameter int WIDTH = 514,
  parameter int CHUNK = 103
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] in_a,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow,
  output logic             lsb
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int LAST_W = WIDTH - (NCHUNK - 1) * CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  localparam logic [1:0] OP_ACC     = 2'b00;
  localparam logic [1:0] OP_ACC_SHR = 2'b01;
  localparam logic [1:0] OP_RESOLVE = 2'b10;
  localparam logic [1:0] OP_CSUB    = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_RES = 2'd1,
    RUN_SUB = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] s_r, c_r, a_r, r_r;
  logic [KW-1:0]    k_r;
  logic             carry_r, borrow_r, done_r;

  logic [WIDTH-1:0] maj_s, acc_s_s, acc_c_s;
  logic [WIDTH-1:0] opnd_s, mask_s, r_nxt_s;
  logic [31:0]      off_s;
  logic [CHUNK-1:0] s_chk_s, o_chk_s;
  logic [CHUNK:0]   sum_s;
  logic             cout_s;

  function automatic logic parity2(input logic x, input logic y);
    return x ^ y;
  endfunction

  // 3:2 compression of S, C and the incoming operand
  always_comb begin
    maj_s   = (s_r & c_r) | (s_r & in_a) | (c_r & in_a);
    acc_s_s = s_r ^ c_r ^ in_a;
    acc_c_s = maj_s << 1;
  end

  // One chunk of S + (C or ~A) + carry; the last chunk may be narrower, so its carry-out sits at LAST_W
  always_comb begin
    off_s   = 32'(k_r) * 32'(CHUNK);
    if (state_r == RUN_SUB) begin
      opnd_s = ~a_r;
    end else begin
      opnd_s = c_r;
    end
    s_chk_s = CHUNK'(s_r >> off_s);
    o_chk_s = CHUNK'(opnd_s >> off_s);
    sum_s   = {1'b0, s_chk_s} + {1'b0, o_chk_s} + {{CHUNK{1'b0}}, carry_r};
    if (k_r == K_LAST) begin
      cout_s = sum_s[LAST_W];
    end else begin
      cout_s = sum_s[CHUNK];
    end
    mask_s  = WIDTH'({CHUNK{1'b1}}) << off_s;
    r_nxt_s = (r_r & ~mask_s) | ((WIDTH'(sum_s[CHUNK-1:0]) << off_s) & mask_s);
  end

  // Command FSM and datapath registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r  <= IDLE;
      s_r      <= '0;
      c_r      <= '0;
      a_r      <= '0;
      r_r      <= '0;
      k_r      <= '0;
      carry_r  <= 1'b0;
      borrow_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_ACC: begin
                s_r    <= acc_s_s;
                c_r    <= acc_c_s;
                done_r <= 1'b1;
              end
              OP_ACC_SHR: begin
                s_r    <= acc_s_s >> 1;
                c_r    <= acc_c_s >> 1;
                done_r <= 1'b1;
              end
              OP_RESOLVE: begin
                k_r     <= '0;
                carry_r <= 1'b0;
                state_r <= RUN_RES;
              end
              OP_CSUB: begin
                a_r     <= in_a;
                k_r     <= '0;
                carry_r <= 1'b1;
                state_r <= RUN_SUB;
              end
              default: state_r <= IDLE;
            endcase
          end
        end
        RUN_RES, RUN_SUB: begin
          r_r     <= r_nxt_s;
          carry_r <= cout_s;
          k_r     <= k_r + KW'(1);
          if (k_r == K_LAST) begin
            k_r     <= '0;
            done_r  <= 1'b1;
            state_r <= IDLE;
            if (state_r == RUN_RES) begin
              s_r <= r_nxt_s;
              c_r <= '0;
            end else begin
              // Final carry-out of S + ~A + 1 is set exactly when S >= A
              borrow_r <= ~cout_s;
              if (cout_s) begin
                s_r <= r_nxt_s;
              end
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_r == IDLE);
  assign done      = done_r;
  assign result    = s_r;
  assign borrow    = borrow_r;
  assign lsb       = parity2(s_r[0], c_r[0]);

endmodule

// File: tb/tb_mp_csa_accum.sv
// Directed bench for mp_csa_accum: a WIDTH=16/CHUNK=5 instance for hand-computed vectors
// and a default-size instance checked against a wide-integer model.
module tb_mp_csa_accum;

  localparam logic [1:0] OP_ACC     = 2'b00;
  localparam logic [1:0] OP_ACC_SHR = 2'b01;
  localparam logic [1:0] OP_RESOLVE = 2'b10;
  localparam logic [1:0] OP_CSUB    = 2'b11;
  localparam int BUDGET = 50;

  logic clk;
  int n_tests = 0;
  int n_fail  = 0;

  logic        rn16, v16, rdy16, done16, bor16, lsb16;
  logic [1:0]  op16;
  logic [15:0] a16, res16;

  logic         rnd, vd, rdyd, doned, bord, lsbd;
  logic [1:0]   opd;
  logic [513:0] ad, resd;

  mp_csa_accum #(.WIDTH(16), .CHUNK(5)) u16 (
    .clk(clk), .resetn(rn16), .cmd_valid(v16), .cmd_ready(rdy16), .cmd_op(op16),
    .in_a(a16), .done(done16), .result(res16), .borrow(bor16), .lsb(lsb16)
  );

  mp_csa_accum u514 (
    .clk(clk), .resetn(rnd), .cmd_valid(vd), .cmd_ready(rdyd), .cmd_op(opd),
    .in_a(ad), .done(doned), .result(resd), .borrow(bord), .lsb(lsbd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [513:0] obs, input logic [513:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue16(input logic [1:0] op, input logic [15:0] a);
    v16 = 1'b1; op16 = op; a16 = a;
    @(posedge clk); #1;
    v16 = 1'b0; a16 = 16'h0000;
  endtask

  task automatic wait_done16(output int lat);
    lat = 1;
    while (!done16 && lat < BUDGET) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic reset16();
    rn16 = 1'b0;
    @(posedge clk); #1;
    rn16 = 1'b1;
  endtask

  initial begin
    int lat;
    logic seen;
    logic [543:0] rnd_w;
    logic [513:0] a_big;
    logic [514:0] vm;
    logic op_bit;

    rn16 = 1'b0; v16 = 1'b0; op16 = 2'b00; a16 = 16'h0000;
    rnd  = 1'b0; vd  = 1'b0; opd  = 2'b00; ad  = '0;
    repeat (2) @(posedge clk);
    #1;
    rn16 = 1'b1; rnd = 1'b1;

    // Reset state
    check("rst_ready16", rdy16, 1'b1);
    check("rst_done16", done16, 1'b0);
    check("rst_result16", res16, 16'h0000);
    check("rst_borrow16", bor16, 1'b0);
    check("rst_lsb16", lsb16, 1'b0);
    check("rst_ready514", rdyd, 1'b1);

    // ACC 0x1234 + 0x0FFF back to back, then RESOLVE
    issue16(OP_ACC, 16'h1234);
    check("acc1_done", done16, 1'b1);
    issue16(OP_ACC, 16'h0FFF);
    check("acc2_done", done16, 1'b1);
    check("acc2_lsb", lsb16, 1'b1);
    issue16(OP_RESOLVE, 16'h0000);
    check("res_busy", rdy16, 1'b0);
    wait_done16(lat);
    check("res_lat16", lat, 5);
    check("res_result", res16, 16'h2233);
    check("res_lsb", lsb16, 1'b1);
    @(posedge clk); #1;
    check("res_done_pulse", done16, 1'b0);

    // Wraparound mod 2^16
    reset16();
    issue16(OP_ACC, 16'hFFFF);
    issue16(OP_ACC, 16'h0003);
    issue16(OP_RESOLVE, 16'h0000);
    wait_done16(lat);
    check("wrap_result", res16, 16'h0002);

    // ACC_SHR: (7 + 8) / 2 = 7
    reset16();
    issue16(OP_ACC, 16'h0007);
    check("shr_lsb_before", lsb16, 1'b1);
    issue16(OP_ACC_SHR, 16'h0008);
    check("shr_done", done16, 1'b1);
    check("shr_lsb_after", lsb16, 1'b1);
    issue16(OP_RESOLVE, 16'h0000);
    wait_done16(lat);
    check("shr_result", res16, 16'h0007);

    // CSUB without and with borrow
    reset16();
    issue16(OP_ACC, 16'h0100);
    issue16(OP_RESOLVE, 16'h0000);
    wait_done16(lat);
    check("sub_setup", res16, 16'h0100);
    issue16(OP_CSUB, 16'h00FF);
    wait_done16(lat);
    check("csub1_lat", lat, 5);
    check("csub1_result", res16, 16'h0001);
    check("csub1_borrow", bor16, 1'b0);
    issue16(OP_CSUB, 16'h0002);
    wait_done16(lat);
    check("csub2_result", res16, 16'h0001);
    check("csub2_borrow", bor16, 1'b1);
    issue16(OP_ACC, 16'h0000);
    check("borrow_hold", bor16, 1'b1);

    // Reset mid-RESOLVE aborts with no done pulse
    issue16(OP_ACC, 16'h0004);
    issue16(OP_RESOLVE, 16'h0000);
    seen = 1'b0;
    @(posedge clk); #1;
    seen = seen | done16;
    rn16 = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      seen = seen | done16;
    end
    rn16 = 1'b1;
    check("abort_ready", rdy16, 1'b1);
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | done16;
    end
    check("abort_no_done", seen, 1'b0);
    check("abort_result", res16, 16'h0000);
    check("abort_borrow", bor16, 1'b0);

    // Default size: random ACC/ACC_SHR against a wide model (operands < 2^500, so no wrap)
    vm = '0;
    for (int i = 0; i < 200; i++) begin
      for (int w = 0; w < 17; w++) rnd_w[w*32 +: 32] = $urandom;
      a_big = '0;
      a_big[499:0] = rnd_w[499:0];
      op_bit = 1'($urandom_range(0, 1));
      vd = 1'b1; opd = {1'b0, op_bit}; ad = a_big;
      @(posedge clk); #1;
      vd = 1'b0;
      vm = vm + {1'b0, a_big};
      if (op_bit) vm = vm >> 1;
      check("big_acc_done", doned, 1'b1);
    end
    check("big_lsb", lsbd, vm[0]);
    vd = 1'b1; opd = OP_RESOLVE; ad = '0;
    @(posedge clk); #1;
    // Commands offered while busy must be ignored
    opd = OP_ACC; ad = '1;
    lat = 1;
    while (!doned && lat < BUDGET) begin
      @(posedge clk); #1;
      lat++;
      if (lat >= 3) vd = 1'b0;
    end
    vd = 1'b0;
    check("big_res_lat", lat, 6);
    check("big_result", resd, vm[513:0]);
    check("big_res_lsb", lsbd, vm[0]);
    @(posedge clk); #1;
    check("big_done_pulse", doned, 1'b0);
    check("big_result_hold", resd, vm[513:0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
